mux_scan_controller: RTL and testbench

//  Drives the s1/s0 selects of a one-bit 4:1 mux and samples its output. It scans the

---
 rtl/mux_scan_controller.sv | 142 ++++++++++++++
 tb/tb_mux_scan_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_controller
//  Description : Scans enabled inputs of a 1-bit 4:1 mux via s1/s0 and returns
//                one sampled bit per channel as a 4-bit word over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_controller #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] chan_mask,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic [3:0] sample_word,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       chan_q,  chan_d;
    logic [3:0]       mask_q,  mask_d;
    logic [3:0]       word_q,  word_d;
    logic             valid_q, valid_d;

    logic             nxt_found;
    logic [1:0]       nxt_idx;

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        lowest_chan = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_chan = 2'(i);
        end
    endfunction

    // Returns {found, index} of the smallest enabled channel above cur.
    function automatic logic [2:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
        next_chan = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_chan = {1'b1, 2'(i)};
        end
    endfunction

    assign {nxt_found, nxt_idx} = next_chan(mask_q, chan_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chan_q  <= 2'd0;
            mask_q  <= 4'd0;
            word_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        mask_d  = mask_q;
        word_d  = word_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start && (chan_mask != 4'd0)) begin
                    mask_d  = chan_mask;
                    word_d  = 4'd0;
                    chan_d  = lowest_chan(chan_mask);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == C_DWELL_LAST) begin
                    word_d[chan_q] = mux_out;
                    cnt_d          = '0;
                    // Last channel keeps its select so the mux input stays put in HOLD.
                    if (nxt_found) begin
                        chan_d = nxt_idx;
                    end else begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    if (continuous) begin
                        word_d  = 4'd0;
                        chan_d  = lowest_chan(mask_q);
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign {s1, s0}    = (state_q == ST_IDLE) ? 2'b00 : chan_q;
    assign sample_word = word_q;
    assign valid       = valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_controller
//  Description : Directed self-checking bench for mux_scan_controller with a
//                behavioural 4:1 mux closing the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic [3:0] chan_mask;
    logic       mux_out;
    logic       s0;
    logic       s1;
    logic [3:0] sample_word;
    logic       valid;
    logic       ready;
    logic       busy;
    logic [3:0] mux_vals;   // {d,c,b,a}

    int total = 0;
    int bad   = 0;

    mux_scan_controller #(.DWELL(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .chan_mask   (chan_mask),
        .mux_out     (mux_out),
        .s0          (s0),
        .s1          (s1),
        .sample_word (sample_word),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy)
    );

    assign mux_out = mux_vals[{s1, s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; chan_mask = 4'd0;
        ready = 1'b0; mux_vals = 4'd0;
        tick(); tick();
        rst_n = 1'b1;
        total++; if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b exp=00", {s1, s0}); end
        total++; if (sample_word !== 4'd0) begin bad++; $display("FAIL reset_word got=%b exp=0000", sample_word); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_scan();
        logic [1:0] exp_sel;
        mux_vals = 4'b1101; chan_mask = 4'b1111; ready = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_sel = 2'(k / 2);
            total++; if ({s1, s0} !== exp_sel) begin bad++; $display("FAIL full_sel k=%0d got=%b exp=%b", k, {s1, s0}, exp_sel); end
            total++; if (valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full_busy k=%0d valid=%b busy=%b exp valid=0 busy=1", k, valid, busy); end
            tick();
        end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", valid); end
        total++; if (sample_word !== 4'b1101) begin bad++; $display("FAIL full_word got=%b exp=1101", sample_word); end
        tick();
        total++; if (valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin bad++; $display("FAIL full_idle valid=%b busy=%b sel=%b exp 0 0 00", valid, busy, {s1, s0}); end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_sel;
        mux_vals = 4'b1111; chan_mask = 4'b1010; ready = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_sel = (k < 2) ? 2'b01 : 2'b11;
            total++; if ({s1, s0} !== exp_sel || valid !== 1'b0) begin bad++; $display("FAIL sparse_sel k=%0d sel=%b valid=%b exp sel=%b valid=0", k, {s1, s0}, valid, exp_sel); end
            tick();
        end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL sparse_valid got=%b exp=1", valid); end
        total++; if (sample_word !== 4'b1010) begin bad++; $display("FAIL sparse_word got=%b exp=1010", sample_word); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sparse_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_zero_mask();
        chan_mask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (busy !== 1'b0 || valid !== 1'b0 || {s1, s0} !== 2'b00) begin bad++; $display("FAIL zero_mask k=%0d busy=%b valid=%b sel=%b exp 0 0 00", k, busy, valid, {s1, s0}); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        mux_vals = 4'b0001; chan_mask = 4'b0001; ready = 1'b0; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        mux_vals = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            total++; if (valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL bp_valid k=%0d valid=%b busy=%b exp 1 1", k, valid, busy); end
            total++; if (sample_word !== 4'b0001 || {s1, s0} !== 2'b00) begin bad++; $display("FAIL bp_frozen k=%0d word=%b sel=%b exp 0001 00", k, sample_word, {s1, s0}); end
            tick();
        end
        ready = 1'b1;
        tick();
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b busy=%b exp 0 0", valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] vals;
        vals = 3'b101;   // channel a value per pass 0,1,2
        mux_vals = {3'b000, vals[0]}; chan_mask = 4'b0001; ready = 1'b1; continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            total++; if (valid !== 1'b0 || busy !== 1'b1 || {s1, s0} !== 2'b00) begin bad++; $display("FAIL b2b_settle p=%0d valid=%b busy=%b sel=%b exp 0 1 00", p, valid, busy, {s1, s0}); end
            chan_mask = 4'b1111; start = 1'b1;
            tick();
            start = 1'b0;
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_early p=%0d valid=%b exp=0", p, valid); end
            tick();
            total++; if (valid !== 1'b1 || sample_word !== {3'b000, vals[p]}) begin bad++; $display("FAIL b2b_word p=%0d valid=%b word=%b exp 1 %b", p, valid, sample_word, {3'b000, vals[p]}); end
            if (p < 2) mux_vals = {3'b000, vals[p+1]};
            continuous = (p < 2);
            tick();
        end
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL b2b_end busy=%b valid=%b exp 0 0", busy, valid); end
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        mux_vals = 4'b1111; chan_mask = 4'b0100; ready = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({s1, s0} !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre sel=%b busy=%b exp 10 1", {s1, s0}, busy); end
        rst_n = 1'b0;
        tick();
        total++; if ({s1, s0} !== 2'b00 || sample_word !== 4'd0 || valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid sel=%b word=%b valid=%b busy=%b exp 00 0000 0 0", {s1, s0}, sample_word, valid, busy); end
        rst_n = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stay busy=%b valid=%b exp 0 0", busy, valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_zero_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
